// File: rtl/jpeg_channel_scheduler_if.sv
// Handshake and data bundle between jpeg_channel_scheduler and its surroundings
// (block source, shared transform core, entropy-coder sink).
interface jpeg_channel_scheduler_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64,
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 3
);
  localparam int BW = DATA_WIDTH * PIXEL_COUNT;

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_CH*BW-1:0] in_block;
  logic [NUM_CH-1:0]    in_ch_en;

  logic                 core_in_valid;
  logic                 core_in_ready;
  logic [BW-1:0]        core_in_block;
  logic [CH_W-1:0]      core_ch;
  logic                 core_luma;
  logic                 core_out_valid;
  logic [BW-1:0]        core_out_block;

  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_CH*BW-1:0] out_block;
  logic [NUM_CH-1:0]    out_ch_en;
  logic                 busy;

  modport slave (
    input  in_valid, in_block, in_ch_en, core_in_ready, core_out_valid,
           core_out_block, out_ready,
    output in_ready, core_in_valid, core_in_block, core_ch, core_luma,
           out_valid, out_block, out_ch_en, busy
  );

  modport master (
    output in_valid, in_block, in_ch_en, core_in_ready, core_out_valid,
           core_out_block, out_ready,
    input  in_ready, core_in_valid, core_in_block, core_ch, core_luma,
           out_valid, out_block, out_ch_en, busy
  );
endinterface

// File: rtl/jpeg_channel_scheduler.sv
// Time-multiplexes the enabled channels of one block through a shared 8x8 transform core.
// Optional JPEG_SCHED_ERRCHK_EN adds a sticky core protocol error flag (err_sticky).
module jpeg_channel_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64,
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 3
) (
  input  logic clk,
  input  logic reset,
  jpeg_channel_scheduler_if.slave bus
`ifdef JPEG_SCHED_ERRCHK_EN
  ,
  output logic err_sticky
`endif
);
  localparam int          BW  = DATA_WIDTH * PIXEL_COUNT;
  localparam int unsigned NCH = NUM_CH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state, state_d;
  logic [NUM_CH*BW-1:0] blk_q, res_q;
  logic [NUM_CH-1:0]    mask_q;
  logic [CH_W-1:0]      ch_q;
  logic [BW-1:0]        core_blk_q;
  logic                 out_valid_q, busy_q;
  logic                 first_hit, next_hit;
  logic [CH_W-1:0]      first_idx, next_idx;

  // Lowest set bit of m at or above start; MSB of the result flags a hit.
  function automatic logic [CH_W:0] scan_up(input logic [NUM_CH-1:0] m,
                                            input int unsigned start);
    logic [CH_W:0] r;
    r = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (m[NCH-1-k] && ((NCH - 1 - k) >= start))
        r = {1'b1, CH_W'(NCH - 1 - k)};
    end
    return r;
  endfunction

  always_comb begin
    {first_hit, first_idx} = scan_up(bus.in_ch_en, 32'd0);
    {next_hit, next_idx}   = scan_up(mask_q, 32'(ch_q) + 32'd1);
    state_d = state;
    case (state)
      S_IDLE:  if (bus.in_valid)       state_d = first_hit ? S_ISSUE : S_DONE;
      S_ISSUE: if (bus.core_in_ready)  state_d = S_WAIT;
      S_WAIT:  if (bus.core_out_valid) state_d = next_hit ? S_ISSUE : S_DONE;
      S_DONE:  if (bus.out_ready)      state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      blk_q       <= '0;
      res_q       <= '0;
      mask_q      <= '0;
      ch_q        <= '0;
      core_blk_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_d;
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            blk_q  <= bus.in_block;
            mask_q <= bus.in_ch_en;
            res_q  <= '0;
            // Core operand is loaded straight from the input so it is ready on the first issue cycle.
            if (first_hit) begin
              ch_q       <= first_idx;
              core_blk_q <= bus.in_block[int'(first_idx)*BW +: BW];
            end
          end
        end
        S_WAIT: begin
          if (bus.core_out_valid) begin
            res_q[int'(ch_q)*BW +: BW] <= bus.core_out_block;
            if (next_hit) begin
              ch_q       <= next_idx;
              core_blk_q <= blk_q[int'(next_idx)*BW +: BW];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JPEG_SCHED_ERRCHK_EN
  logic [9:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (bus.core_out_valid && (state != S_WAIT))
        err_sticky <= 1'b1;
      // Counter saturates on the 1024th unanswered issue cycle.
      if ((state == S_ISSUE) && !bus.core_in_ready) begin
        if (stall_cnt == '1)
          err_sticky <= 1'b1;
        else
          stall_cnt <= stall_cnt + 10'd1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

  assign bus.in_ready      = (state == S_IDLE) && !reset;
  assign bus.core_in_valid = (state == S_ISSUE);
  assign bus.core_in_block = core_blk_q;
  assign bus.core_ch       = ch_q;
  assign bus.core_luma     = (ch_q == '0);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_block     = res_q;
  assign bus.out_ch_en     = mask_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_jpeg_channel_scheduler.sv
// Bench for jpeg_channel_scheduler: table-driven latency vectors, directed corner sequences and
// randomized traffic scored against a per-block reference model (NUM_CH=3 and NUM_CH=1 instances).
module tb_jpeg_channel_scheduler;
  localparam int DW = 32;
  localparam int PC = 64;
  localparam int BW = DW * PC;
  localparam int NC = 3;
  localparam int NB = NC * BW;

  typedef struct {
    logic [NB-1:0] blk;
    logic [NC-1:0] mask;
  } exp_t;

  typedef struct {
    logic [NC-1:0] mask;
    int            lat;
    int            exp_lat;
    int            exp_iss;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_iss = 0;
  int   n_civ = 0;
  int   n_xfer = 0;
  int   lat = 5;
  bit   rnd_on = 1'b0;

  exp_t          exp_q[$];
  int            iss_q[$];
  logic [NB-1:0] cur_blk = '0;

  jpeg_channel_scheduler_if #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC), .NUM_CH(NC), .CH_W(3)) bus ();
  jpeg_channel_scheduler_if #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC), .NUM_CH(1), .CH_W(1)) bus1 ();

`ifdef JPEG_SCHED_ERRCHK_EN
  logic err0, err1;
`endif

  jpeg_channel_scheduler #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC), .NUM_CH(NC), .CH_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef JPEG_SCHED_ERRCHK_EN
    , .err_sticky(err0)
`endif
  );

  jpeg_channel_scheduler #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC), .NUM_CH(1), .CH_W(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef JPEG_SCHED_ERRCHK_EN
    , .err_sticky(err1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the transform core: every sample scaled and tagged with its channel.
  function automatic logic [BW-1:0] xform(input logic [BW-1:0] b, input int c);
    logic [BW-1:0] r;
    for (int i = 0; i < PC; i++) r[i*DW +: DW] = b[i*DW +: DW] * 32'd3 + 32'(c) + 32'h100;
    return r;
  endfunction

  function automatic logic [NB-1:0] model_out(input logic [NB-1:0] b, input logic [NC-1:0] m);
    logic [NB-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) if (m[c]) r[c*BW +: BW] = xform(b[c*BW +: BW], c);
    return r;
  endfunction

  function automatic logic [NB-1:0] const_blk();
    logic [NB-1:0] r;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < PC; i++) r[(c*PC + i)*DW +: DW] = 32'(c + 1);
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_blk();
    logic [NB-1:0] r;
    for (int i = 0; i < NB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low64 %h expected low64 %h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
    end
  endtask

  initial begin : core_model
    logic hs;
    logic [BW-1:0] hblk, pblk;
    int hch, pch, cd;
    hs = 1'b0; hblk = '0; pblk = '0; hch = 0; pch = 0; cd = 0;
    bus.core_out_valid = 1'b0;
    bus.core_out_block = '0;
    forever begin
      @(negedge clk);
      hs   = bus.core_in_valid && bus.core_in_ready && !reset;
      hblk = bus.core_in_block;
      hch  = int'(bus.core_ch);
      @(posedge clk); #1;
      bus.core_out_valid = 1'b0;
      if (reset) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.core_out_valid = 1'b1;
          bus.core_out_block = xform(pblk, pch);
        end
      end
      if (hs) begin
        pblk = hblk; pch = hch;
        if (lat <= 1) begin
          bus.core_out_valid = 1'b1;
          bus.core_out_block = xform(pblk, pch);
        end else cd = lat - 1;
      end
    end
  end

  // Scoreboard/monitor: issue order, operand stability under stall, output transfers.
  logic          st_core = 1'b0, st_out = 1'b0;
  logic [2:0]    hold_ch = '0;
  logic [BW-1:0] hold_blk = '0;
  logic [NB-1:0] hold_out = '0;
  int            mon_ch;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (reset) begin
      st_core = 1'b0;
      st_out  = 1'b0;
    end else begin
      if (st_core) begin
        chk("core_hold_valid", 32'(bus.core_in_valid), 32'd1);
        chk("core_hold_ch", 32'(bus.core_ch), 32'(hold_ch));
        chk_blk("core_hold_blk", NB'(bus.core_in_block), NB'(hold_blk));
      end
      st_core  = bus.core_in_valid && !bus.core_in_ready;
      hold_ch  = bus.core_ch;
      hold_blk = bus.core_in_block;
      if (bus.busy) chk("ch_range", 32'(bus.core_ch <= 3'(NC - 1)), 32'd1);
      if (bus.core_in_valid) n_civ++;
      if (bus.core_in_valid && bus.core_in_ready) begin
        n_iss++;
        chk("issue_expected", 32'(iss_q.size() > 0), 32'd1);
        if (iss_q.size() > 0) begin
          mon_ch = iss_q.pop_front();
          chk("issue_ch", 32'(bus.core_ch), 32'(mon_ch));
          chk("core_luma", 32'(bus.core_luma), 32'(mon_ch == 0));
          chk_blk("issue_blk", NB'(bus.core_in_block), NB'(cur_blk[mon_ch*BW +: BW]));
        end
      end
      if (st_out) begin
        chk("out_hold_valid", 32'(bus.out_valid), 32'd1);
        chk_blk("out_hold_blk", bus.out_block, hold_out);
      end
      if (bus.out_valid) chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      st_out   = bus.out_valid && !bus.out_ready;
      hold_out = bus.out_block;
      if (bus.out_valid && bus.out_ready) begin
        n_xfer++;
        chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
        chk("all_issued", 32'(iss_q.size()), 32'd0);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk_blk("xfer_block", bus.out_block, mon_e.blk);
          chk("xfer_mask", 32'(bus.out_ch_en), 32'(mon_e.mask));
        end
      end
    end
  end

  task automatic send(input logic [NB-1:0] b, input logic [NC-1:0] m, output int t_acc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    t_acc = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_block = b; bus.in_ch_en = m;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; t_acc = cyc; break; end
    end
    if (ok) begin
      e.blk = model_out(b, m); e.mask = m;
      exp_q.push_back(e);
      cur_blk = b;
      for (int c = 0; c < NC; c++) if (m[c]) iss_q.push_back(c);
    end
    chk("send_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int t_out);
    bit ok;
    ok = 1'b0;
    t_out = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1'b1; t_out = cyc; break; end
    end
    chk("out_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t          tab[6];
    int            t_acc, t_out, i0, c0, x0;
    bit            found;
    logic [BW-1:0] b1;

    tab[0] = '{mask: 3'b111, lat: 5, exp_lat: 19, exp_iss: 3};
    tab[1] = '{mask: 3'b101, lat: 5, exp_lat: 13, exp_iss: 2};
    tab[2] = '{mask: 3'b000, lat: 5, exp_lat: 1,  exp_iss: 0};
    tab[3] = '{mask: 3'b010, lat: 1, exp_lat: 3,  exp_iss: 1};
    tab[4] = '{mask: 3'b100, lat: 3, exp_lat: 5,  exp_iss: 1};
    tab[5] = '{mask: 3'b011, lat: 2, exp_lat: 7,  exp_iss: 2};

    bus.in_valid = 1'b0; bus.in_block = '0; bus.in_ch_en = '0;
    bus.core_in_ready = 1'b1; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_block = '0; bus1.in_ch_en = '0;
    bus1.core_in_ready = 1'b1; bus1.out_ready = 1'b1;
    bus1.core_out_valid = 1'b0; bus1.core_out_block = '0;

    fork
      forever begin
        @(posedge clk); #1;
        if (rnd_on) begin
          bus.core_in_ready = ($urandom_range(0, 3) != 0);
          bus.out_ready     = ($urandom_range(0, 2) != 0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_core_valid", 32'(bus.core_in_valid), 32'd0);
    chk("rst_core_ch", 32'(bus.core_ch), 32'd0);
    chk("rst_out_ch_en", 32'(bus.out_ch_en), 32'd0);
    chk_blk("rst_out_block", bus.out_block, '0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency / issue-count table with the slice c = c+1 block
    foreach (tab[v]) begin
      lat = tab[v].lat;
      i0 = n_iss; c0 = n_civ;
      send(const_blk(), tab[v].mask, t_acc);
      wait_out(t_out);
      chk("latency", 32'(t_out - t_acc), 32'(tab[v].exp_lat));
      drain(20);
      chk("issue_count", 32'(n_iss - i0), 32'(tab[v].exp_iss));
      chk("core_valid_cycles", 32'(n_civ - c0), 32'(tab[v].exp_iss));
    end

    // Core stall then output stall
    bus.core_in_ready = 1'b0; bus.out_ready = 1'b0; lat = 3;
    x0 = n_xfer;
    send(rand_blk(), 3'b111, t_acc);
    repeat (4) @(posedge clk);
    #1 bus.core_in_ready = 1'b1;
    wait_out(t_out);
    repeat (10) @(negedge clk);
    chk("bp_no_xfer", 32'(n_xfer - x0), 32'd0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    drain(50);
    repeat (5) @(negedge clk);
    chk("bp_one_xfer", 32'(n_xfer - x0), 32'd1);

    // Reset while channel 1's result arrives
    lat = 5;
    send(const_blk(), 3'b111, t_acc);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.core_out_valid && bus.core_ch == 3'd1) begin found = 1'b1; break; end
    end
    chk("rst_trigger_seen", 32'(found), 32'd1);
    reset = 1'b1;
    exp_q.delete(); iss_q.delete();
    #1 chk("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_core_valid", 32'(bus.core_in_valid), 32'd0);
    chk_blk("mid_rst_out_block", bus.out_block, '0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    x0 = n_xfer;
    send(rand_blk(), 3'b111, t_acc);
    drain(100);
    chk("post_rst_xfer", 32'(n_xfer - x0), 32'd1);

    // Back-to-back blocks
    lat = 2;
    x0 = n_xfer;
    for (int k = 0; k < 4; k++) send(rand_blk(), 3'($urandom_range(0, 7)), t_acc);
    drain(200);
    chk("b2b_xfers", 32'(n_xfer - x0), 32'd4);

    // Randomized traffic with random backpressure on both sides
    rnd_on = 1'b1;
    x0 = n_xfer;
    for (int k = 0; k < 8; k++) begin
      lat = $urandom_range(1, 6);
      send(rand_blk(), 3'($urandom_range(0, 7)), t_acc);
    end
    drain(2000);
    chk("rand_xfers", 32'(n_xfer - x0), 32'd8);
    rnd_on = 1'b0;
    @(posedge clk); #2;
    bus.core_in_ready = 1'b1; bus.out_ready = 1'b1;

    // Single-channel instance
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < PC; i++) b1[i*DW +: DW] = $urandom;
      @(posedge clk); #1;
      bus1.in_valid = 1'b1; bus1.in_block = b1; bus1.in_ch_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus1.in_ready) begin found = 1'b1; break; end
      end
      chk("n1_accept", 32'(found), 32'd1);
      @(posedge clk); #1 bus1.in_valid = 1'b0;
      @(negedge clk);
      chk("n1_core_valid", 32'(bus1.core_in_valid), 32'd1);
      chk("n1_core_ch", 32'(bus1.core_ch), 32'd0);
      chk("n1_core_luma", 32'(bus1.core_luma), 32'd1);
      chk_blk("n1_core_blk", NB'(bus1.core_in_block), NB'(b1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus1.core_out_valid = 1'b1; bus1.core_out_block = xform(b1, 0);
      @(negedge clk);
      chk("n1_wait_ch", 32'(bus1.core_ch), 32'd0);
      chk("n1_not_done", 32'(bus1.out_valid), 32'd0);
      @(posedge clk); #1 bus1.core_out_valid = 1'b0;
      @(negedge clk);
      chk("n1_out_valid", 32'(bus1.out_valid), 32'd1);
      chk_blk("n1_out_block", NB'(bus1.out_block), NB'(xform(b1, 0)));
      chk("n1_out_ch_en", 32'(bus1.out_ch_en), 32'd1);
      @(negedge clk);
      chk("n1_back_idle", 32'(bus1.in_ready), 32'd1);
    end

`ifdef JPEG_SCHED_ERRCHK_EN
    chk("err_sticky_clean", 32'(err0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
